order_executor: RTL and testbench

Consumes the one-cycle `buy_signal`/`sell_signal` pulses from the moving-average crossover engine and turns them into orders on a valid/ready order port. It waits for an exchange acknowledgement and tracks the resulting signed position and cash. It sits between the signal engine and the exchange-side order interface, and is the receiving end of the signal stream.

---
 rtl/trading_pkg.sv | 18 +
 rtl/exec_timer.sv | 34 +++
 rtl/order_executor.sv | 182 ++++++++++++++++++
 tb/tb_order_executor.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trading_pkg.sv
// Shared types and widths for the order execution path.
package trading_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StWaitAck,
        StCooldown
    } exec_state_e;

    localparam logic SIDE_BUY  = 1'b1;
    localparam logic SIDE_SELL = 1'b0;

    localparam int unsigned PRICE_W = 8;
    localparam int unsigned POS_W   = 8;
    localparam int unsigned CASH_W  = 24;

endpackage

// File: rtl/exec_timer.sv
// Loadable down-counter; done_o is high while the count is zero.
module exec_timer #(
    parameter int unsigned Width = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             dec_i,
    output logic             done_o
);

    logic [Width-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = (count_q == '0);

endmodule

// File: rtl/order_executor.sv
// Turns buy/sell pulses into exchange orders, waits for the ack and tracks position and cash.
module order_executor
    import trading_pkg::*;
#(
    parameter int unsigned QTY         = 1,
    parameter int unsigned MAX_POS     = 4,
    parameter int unsigned COOLDOWN    = 3,
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PRICE_W-1:0]  price_in_i,
    input  logic                buy_signal_i,
    input  logic                sell_signal_i,
    output logic                order_valid_o,
    input  logic                order_ready_i,
    output logic                order_side_o,
    output logic [PRICE_W-1:0]  order_price_o,
    output logic [7:0]          order_qty_o,
    input  logic                ack_valid_i,
    input  logic                ack_fill_i,
    output logic [POS_W-1:0]    position_o,
    output logic [CASH_W-1:0]   cash_o,
    output logic                busy_o,
    output logic                timeout_err_o,
    output logic [7:0]          drop_count_o
);

    localparam int unsigned TimerW = 16;
    localparam logic [TimerW-1:0] AckLoad  = TimerW'(ACK_TIMEOUT - 1);
    localparam logic [TimerW-1:0] CoolLoad = TimerW'(COOLDOWN - 1);
    localparam logic [7:0]        QtyVal   = 8'(QTY);

    exec_state_e         state_q, state_d;
    logic                side_q, side_d;
    logic [PRICE_W-1:0]  price_q, price_d;
    logic [7:0]          qty_q, qty_d;
    logic                valid_q, valid_d;
    logic                busy_q, busy_d;
    logic                terr_q, terr_d;
    logic [POS_W-1:0]    pos_q, pos_d;
    logic [CASH_W-1:0]   cash_q, cash_d;
    logic [7:0]          drop_q, drop_d;

    logic                tmr_load, tmr_dec, tmr_done;
    logic [TimerW-1:0]   tmr_load_val;
    logic                drop;
    logic                can_buy, can_sell;
    logic [15:0]         notional;
    logic [CASH_W-1:0]   notional_ext;
    int                  pos_int;

    // Limit checks in full signed int so the +/-QTY step cannot overflow POS_W.
    always_comb begin
        pos_int      = int'($signed(pos_q));
        can_buy      = (pos_int + int'(QTY)) <= int'(MAX_POS);
        can_sell     = (pos_int - int'(QTY)) >= -int'(MAX_POS);
        notional     = {8'b0, price_q} * {8'b0, QtyVal};
        notional_ext = {{(CASH_W - 16){1'b0}}, notional};
    end

    always_comb begin
        state_d      = state_q;
        side_d       = side_q;
        price_d      = price_q;
        qty_d        = qty_q;
        pos_d        = pos_q;
        cash_d       = cash_q;
        terr_d       = 1'b0;
        tmr_load     = 1'b0;
        tmr_load_val = AckLoad;
        tmr_dec      = 1'b0;
        drop         = 1'b0;

        case (state_q)
            StIdle: begin
                if (buy_signal_i && sell_signal_i) begin
                    drop = 1'b1;
                end else if (buy_signal_i || sell_signal_i) begin
                    if (buy_signal_i ? can_buy : can_sell) begin
                        side_d  = buy_signal_i ? SIDE_BUY : SIDE_SELL;
                        price_d = price_in_i;
                        qty_d   = QtyVal;
                        state_d = StSend;
                    end else begin
                        drop = 1'b1;
                    end
                end
            end
            StSend: begin
                drop = buy_signal_i || sell_signal_i;
                if (order_ready_i) begin
                    state_d      = StWaitAck;
                    tmr_load     = 1'b1;
                    tmr_load_val = AckLoad;
                end
            end
            StWaitAck: begin
                drop = buy_signal_i || sell_signal_i;
                // An ack on the final timeout cycle takes priority over the error.
                if (ack_valid_i || tmr_done) begin
                    if (ack_valid_i && ack_fill_i) begin
                        if (side_q == SIDE_BUY) begin
                            pos_d  = pos_q + QtyVal;
                            cash_d = cash_q - notional_ext;
                        end else begin
                            pos_d  = pos_q - QtyVal;
                            cash_d = cash_q + notional_ext;
                        end
                    end
                    terr_d       = !ack_valid_i;
                    state_d      = StCooldown;
                    tmr_load     = 1'b1;
                    tmr_load_val = CoolLoad;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            StCooldown: begin
                drop = buy_signal_i || sell_signal_i;
                if (tmr_done) begin
                    state_d = StIdle;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        drop_d  = (drop && (drop_q != 8'hFF)) ? drop_q + 8'd1 : drop_q;
        valid_d = (state_d == StSend);
        busy_d  = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            side_q  <= 1'b0;
            price_q <= '0;
            qty_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            terr_q  <= 1'b0;
            pos_q   <= '0;
            cash_q  <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            side_q  <= side_d;
            price_q <= price_d;
            qty_q   <= qty_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            terr_q  <= terr_d;
            pos_q   <= pos_d;
            cash_q  <= cash_d;
            drop_q  <= drop_d;
        end
    end

    exec_timer #(
        .Width(TimerW)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (tmr_load),
        .load_val_i(tmr_load_val),
        .dec_i     (tmr_dec),
        .done_o    (tmr_done)
    );

    assign order_valid_o = valid_q;
    assign order_side_o  = side_q;
    assign order_price_o = price_q;
    assign order_qty_o   = qty_q;
    assign position_o    = pos_q;
    assign cash_o        = cash_q;
    assign busy_o        = busy_q;
    assign timeout_err_o = terr_q;
    assign drop_count_o  = drop_q;

endmodule

// File: tb/tb_order_executor.sv
// Bench for order_executor: vector table, directed corner sequences and a random run vs. a timeline model.
module tb_order_executor;

    localparam int QTY = 1;
    localparam int MAX_POS = 4;
    localparam int COOLDOWN = 3;
    localparam int ACK_TIMEOUT = 15;

    logic clk = 1'b0;
    logic rst_n;
    logic [7:0] price_in;
    logic buy, sell, ready, ack_v, ack_f;
    logic order_valid, order_side, busy, terr;
    logic [7:0] order_price, order_qty, position, drop_count;
    logic [23:0] cash;

    int checks = 0;
    int errors = 0;

    order_executor #(
        .QTY(QTY), .MAX_POS(MAX_POS), .COOLDOWN(COOLDOWN), .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .price_in_i   (price_in),
        .buy_signal_i (buy),
        .sell_signal_i(sell),
        .order_valid_o(order_valid),
        .order_ready_i(ready),
        .order_side_o (order_side),
        .order_price_o(order_price),
        .order_qty_o  (order_qty),
        .ack_valid_i  (ack_v),
        .ack_fill_i   (ack_f),
        .position_o   (position),
        .cash_o       (cash),
        .busy_o       (busy),
        .timeout_err_o(terr),
        .drop_count_o (drop_count)
    );

    always #5 clk = ~clk;

    // Timeline model: an order is described by absolute edge numbers of its deadlines.
    int m_cyc = 0;
    bit m_send;
    int m_wait_end;
    int m_cool_end;
    bit m_side;
    logic [7:0] m_price, m_qty;
    int m_pos, m_drop;
    logic [23:0] m_cash;
    bit m_terr;

    task automatic model_reset();
        m_send = 0; m_wait_end = -1; m_cool_end = -1;
        m_side = 0; m_price = '0; m_qty = '0;
        m_pos = 0; m_drop = 0; m_cash = '0; m_terr = 0;
    endtask

    task automatic model_edge();
        bit was_idle, was_send, was_wait, was_cool, dropped;
        logic [23:0] notion;
        m_cyc++;
        was_send = m_send;
        was_wait = (m_wait_end >= 0);
        was_cool = (m_cool_end >= 0);
        was_idle = !was_send && !was_wait && !was_cool;
        m_terr = 0;
        dropped = 0;
        if (was_idle) begin
            if (buy && sell) dropped = 1;
            else if (buy || sell) begin
                if (buy ? (m_pos + QTY <= MAX_POS) : (m_pos - QTY >= -MAX_POS)) begin
                    m_send = 1; m_side = buy; m_price = price_in; m_qty = 8'(QTY);
                end else dropped = 1;
            end
        end else if (buy || sell) dropped = 1;
        if (dropped && m_drop < 255) m_drop++;
        if (was_send && ready) begin
            m_send = 0;
            m_wait_end = m_cyc + ACK_TIMEOUT;
        end
        if (was_wait) begin
            if (ack_v) begin
                if (ack_f) begin
                    notion = 24'(m_price * QTY);
                    if (m_side) begin m_pos += QTY; m_cash = m_cash - notion; end
                    else begin m_pos -= QTY; m_cash = m_cash + notion; end
                end
                m_wait_end = -1;
                m_cool_end = m_cyc + COOLDOWN;
            end else if (m_cyc == m_wait_end) begin
                m_terr = 1;
                m_wait_end = -1;
                m_cool_end = m_cyc + COOLDOWN;
            end
        end
        if (was_cool && m_cyc == m_cool_end) m_cool_end = -1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("valid", order_valid, m_send);
        chk("side", order_side, m_side);
        chk("price", order_price, m_price);
        chk("qty", order_qty, m_qty);
        chk("position", position, m_pos[7:0]);
        chk("cash", cash, m_cash);
        chk("busy", busy, m_send || (m_wait_end >= 0) || (m_cool_end >= 0));
        chk("timeout_err", terr, m_terr);
        chk("drop_count", drop_count, m_drop[7:0]);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic clear_inputs();
        buy = 0; sell = 0; ready = 0; ack_v = 0; ack_f = 0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && busy; i++) tick();
        chk("idle_reached", busy, 1'b0);
    endtask

    task automatic run_order(input bit side, input logic [7:0] price, input int rdy_wait,
                             input int ack_wait, input int ack_kind);
        price_in = price; buy = side; sell = !side;
        tick();
        buy = 0; sell = 0;
        repeat (rdy_wait) tick();
        ready = 1;
        tick();
        ready = 0;
        repeat (ack_wait) tick();
        if (ack_kind < 2) begin
            ack_v = 1; ack_f = (ack_kind == 0);
            tick();
            ack_v = 0; ack_f = 0;
        end
        wait_idle();
    endtask

    typedef struct {
        logic buy, sell, ready, ack_v, ack_f;
        logic exp_valid, exp_busy;
        logic [7:0] exp_pos;
        logic [23:0] exp_cash;
        logic [7:0] exp_drop;
    } vec_t;

    vec_t vecs[9];
    int hs_k, pulses;

    initial begin
        // Basic buy at 100, stray ack and simultaneous signals afterwards.
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0, 24'd0,       8'd0};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 24'd0,       8'd0};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 24'd0,       8'd0};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd1, 24'hFFFF9C,  8'd0};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 24'hFFFF9C,  8'd0};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 24'hFFFF9C,  8'd0};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 24'hFFFF9C,  8'd0};
        vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 24'hFFFF9C,  8'd1};
        vecs[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1, 24'hFFFF9C,  8'd1};

        rst_n = 0; price_in = 8'd100;
        clear_inputs();
        model_reset();
        #12;
        check_all();
        @(negedge clk);
        rst_n = 1;

        for (int i = 0; i < 9; i++) begin
            buy = vecs[i].buy; sell = vecs[i].sell; ready = vecs[i].ready;
            ack_v = vecs[i].ack_v; ack_f = vecs[i].ack_f;
            tick();
            chk("vec_valid", order_valid, vecs[i].exp_valid);
            chk("vec_busy", busy, vecs[i].exp_busy);
            chk("vec_pos", position, vecs[i].exp_pos);
            chk("vec_cash", cash, vecs[i].exp_cash);
            chk("vec_drop", drop_count, vecs[i].exp_drop);
            if (i == 0) begin
                chk("vec_side", order_side, 1'b1);
                chk("vec_price", order_price, 8'd100);
                chk("vec_qty", order_qty, 8'd1);
            end
        end
        clear_inputs();

        // Position limit: fill up to +4, a further buy is dropped, a sell goes through.
        repeat (3) run_order(1'b1, 8'd10, 0, 0, 0);
        chk("limit_pos", position, 8'd4);
        buy = 1; tick(); buy = 0;
        chk("limit_no_order", order_valid, 1'b0);
        chk("limit_drop", drop_count, 8'd2);
        sell = 1; price_in = 8'd12; tick(); sell = 0;
        chk("limit_sell_valid", order_valid, 1'b1);
        chk("limit_sell_side", order_side, 1'b0);
        ready = 1; tick(); ready = 0;
        ack_v = 1; ack_f = 1; tick(); ack_v = 0; ack_f = 0;
        wait_idle();
        chk("limit_sell_pos", position, 8'd3);

        // Backpressure: price held while the feed moves; 5 pulses dropped.
        price_in = 8'd50; buy = 1; tick();
        for (int i = 0; i < 10; i++) begin
            price_in = 8'(60 + i);
            buy = (i % 2 == 0);
            tick();
            chk("bp_price_hold", order_price, 8'd50);
            chk("bp_valid_hold", order_valid, 1'b1);
        end
        buy = 0;
        chk("bp_drop", drop_count, 8'd7);
        ready = 1; tick(); ready = 0;
        ack_v = 1; ack_f = 1; tick(); ack_v = 0; ack_f = 0;
        wait_idle();
        chk("bp_pos", position, 8'd4);

        // Rejected ack leaves position and cash alone.
        run_order(1'b0, 8'd80, 2, 1, 1);
        chk("reject_pos", position, 8'd4);
        chk("reject_cash", cash, m_cash);

        // Timeout: exactly one pulse, ACK_TIMEOUT edges after the handshake edge.
        price_in = 8'd70; sell = 1; tick(); sell = 0;
        ready = 1; tick(); ready = 0;
        pulses = 0; hs_k = -1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (terr) begin pulses++; hs_k = k; end
        end
        chk("timeout_pulses", pulses, 1);
        chk("timeout_cycle", hs_k, ACK_TIMEOUT);
        chk("timeout_pos", position, 8'd4);
        wait_idle();

        // Ack on the timeout edge counts as a fill.
        price_in = 8'd90; sell = 1; tick(); sell = 0;
        ready = 1; tick(); ready = 0;
        repeat (ACK_TIMEOUT - 1) tick();
        ack_v = 1; ack_f = 1; tick(); ack_v = 0; ack_f = 0;
        chk("ack_at_timeout_err", terr, 1'b0);
        chk("ack_at_timeout_pos", position, 8'd3);
        wait_idle();

        // Reset while waiting for an ack, then a clean order.
        price_in = 8'd20; buy = 1; tick(); buy = 0;
        ready = 1; tick(); ready = 0;
        tick();
        #2;
        rst_n = 0;
        #1;
        model_reset();
        check_all();
        chk("rst_busy", busy, 1'b0);
        chk("rst_drop", drop_count, 8'd0);
        @(negedge clk);
        rst_n = 1;
        run_order(1'b1, 8'd33, 1, 0, 0);
        chk("post_rst_pos", position, 8'd1);
        chk("post_rst_cash", cash, 24'hFFFFDF);

        // Random traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            price_in = 8'($urandom_range(0, 255));
            buy = ($urandom_range(0, 5) == 0);
            sell = ($urandom_range(0, 5) == 0);
            ready = ($urandom_range(0, 1) == 1);
            ack_v = ($urandom_range(0, 4) == 0);
            ack_f = ($urandom_range(0, 2) != 0);
            tick();
        end
        clear_inputs();
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
